// File: rtl/branch_predictor_table_if.sv
// branch_predictor_table_if: lookup/update bus between fetch, branch resolution and the predictor table.
interface branch_predictor_table_if #(
    parameter int PC_W   = 32,
    parameter int IDX_W  = 4,
    parameter int HIST_W = 4
);
    logic [PC_W-1:0]   lookup_pc_i;
    logic [IDX_W-1:0]  lookup_idx_o;
    logic              predict_o;
    logic              ready_o;
    logic              update_i;
    logic [IDX_W-1:0]  update_idx_i;
    logic              result_i;
    logic [HIST_W-1:0] ghr_o;
    modport master (
        output lookup_pc_i, update_i, update_idx_i, result_i,
        input  lookup_idx_o, predict_o, ready_o, ghr_o
    );
    modport slave (
        input  lookup_pc_i, update_i, update_idx_i, result_i,
        output lookup_idx_o, predict_o, ready_o, ghr_o
    );
endinterface

// File: rtl/branch_predictor_table.sv
// branch_predictor_table: table of saturating counters with reset sweep; define BRANCH_PREDICTOR_GSHARE_EN
// to XOR the lookup index with a non-speculative global history register.
module branch_predictor_table #(
    parameter int              PC_W     = 32,
    parameter int              IDX_W    = 4,
    parameter int              CNT_W    = 2,
    parameter logic [CNT_W-1:0] INIT_VAL = {CNT_W{1'b1}},
    parameter int              HIST_W   = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    branch_predictor_table_if.slave  bus
);
    localparam int ENTRIES = 1 << IDX_W;
    typedef enum logic {INIT, READY} state_t;
    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q [ENTRIES];
    logic [CNT_W-1:0]   cnt_d [ENTRIES];
    logic [CNT_W-1:0]   upd_cur;
    logic [IDX_W-1:0]   base, idx;
    logic [HIST_W-1:0]  ghr;
    logic               ready;
    logic               unused_pc;
    assign base      = bus.lookup_pc_i[IDX_W+1:2];
    assign unused_pc = ^{bus.lookup_pc_i[PC_W-1:IDX_W+2], bus.lookup_pc_i[1:0]};
    assign ready     = state_q == READY;
    assign upd_cur   = cnt_q[bus.update_idx_i];
`ifdef BRANCH_PREDICTOR_GSHARE_EN
    logic [HIST_W-1:0] ghr_q, ghr_d;
    logic [HIST_W:0]   ghr_shift;
    assign ghr_shift = {ghr_q, bus.result_i};
    always_comb ghr_d = (ready && bus.update_i) ? ghr_shift[HIST_W-1:0] : ghr_q;
    always_ff @(posedge clk_i) begin
        if (rst_i) ghr_q <= '0;
        else       ghr_q <= ghr_d;
    end
    assign ghr = ghr_q;
    assign idx = base ^ IDX_W'(ghr_q);
`else
    assign ghr = '0;
    assign idx = base;
`endif
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (state_q == INIT) begin
            cnt_d[ptr_q] = INIT_VAL;
            ptr_d        = ptr_q + 1'b1;
            state_d      = (ptr_q == '1) ? READY : INIT;
        end else if (bus.update_i) begin
            cnt_d[bus.update_idx_i] = bus.result_i ? ((upd_cur == '1) ? upd_cur : upd_cur + 1'b1)
                                                   : ((upd_cur == '0) ? upd_cur : upd_cur - 1'b1);
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end
    // Storage is not reset directly; the sweep rewrites every entry after each reset.
    always_ff @(posedge clk_i) cnt_q <= cnt_d;
    assign bus.lookup_idx_o = idx;
    assign bus.ready_o      = ready;
    assign bus.predict_o    = ready ? cnt_q[idx][CNT_W-1] : INIT_VAL[CNT_W-1];
    assign bus.ghr_o        = ghr;
endmodule

// File: tb/tb_branch_predictor_table.sv
// tb_branch_predictor_table: directed plus randomized checks against an integer counter-table model.
module tb_branch_predictor_table;
    localparam int PC_W = 32, IDX_W = 4, CNT_W = 2, HIST_W = 4, N = 16;
`ifdef BRANCH_PREDICTOR_GSHARE_EN
    localparam bit GS = 1'b1;
`else
    localparam bit GS = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    branch_predictor_table_if #(.PC_W(PC_W), .IDX_W(IDX_W), .HIST_W(HIST_W)) bus ();
    branch_predictor_table #(.PC_W(PC_W), .IDX_W(IDX_W), .CNT_W(CNT_W), .HIST_W(HIST_W)) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus)
    );
    int checks = 0, failures = 0;
    int cnt [N];
    int ghr = 0, sweep = 0;
    bit rdy = 1'b0;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    function automatic int hist();
        return GS ? ghr : 0;
    endfunction
    function automatic logic [31:0] pc_for(input int e);
        logic [31:0] r;
        r = $urandom;
        return (r & ~32'((N - 1) << 2)) | 32'(((e ^ hist()) & (N - 1)) << 2);
    endfunction
    task automatic drive(input logic [31:0] pc, input logic upd, input int uidx, input logic res);
        int e;
        bus.lookup_pc_i  = pc;
        bus.update_i     = upd;
        bus.update_idx_i = IDX_W'(uidx);
        bus.result_i     = res;
        #1;
        e = int'((pc >> 2) & (N - 1)) ^ hist();
        chk("lookup_idx", 32'(bus.lookup_idx_o), 32'(e));
        chk("predict", 32'(bus.predict_o), rdy ? 32'(cnt[e] >= 2) : 32'd1);
        chk("ready", 32'(bus.ready_o), 32'(rdy));
        chk("ghr", 32'(bus.ghr_o), 32'(hist()));
    endtask
    task automatic rand_drive();
        drive($urandom, 1'($urandom), int'($urandom_range(0, N - 1)), 1'($urandom));
    endtask
    task automatic tick();
        int i;
        @(posedge clk);
        if (rst) begin
            rdy = 1'b0; sweep = 0; ghr = 0;
        end else if (!rdy) begin
            sweep++;
            if (sweep == N) begin
                rdy = 1'b1;
                foreach (cnt[k]) cnt[k] = 3;
            end
        end else if (bus.update_i) begin
            i = int'(bus.update_idx_i);
            cnt[i] = bus.result_i ? ((cnt[i] == 3) ? 3 : cnt[i] + 1) : ((cnt[i] == 0) ? 0 : cnt[i] - 1);
            ghr = ((ghr << 1) | int'(bus.result_i)) & (N - 1);
        end
        #1;
    endtask
    task automatic sweep_wait();
        int n;
        n = 0;
        while (!bus.ready_o && n < 40) begin
            rand_drive();
            tick();
            n++;
        end
        chk("sweep_len", 32'(n), 32'd16);
    endtask
    task automatic check_all_taken();
        for (int e = 0; e < N; e++) begin
            drive(pc_for(e), 1'b0, 0, 1'b0);
            chk("swept_entry", 32'(bus.predict_o), 32'd1);
        end
    endtask
    initial begin
        int exp_down [4] = '{1, 0, 0, 0};
        int exp_up [4] = '{0, 1, 1, 1};
        foreach (cnt[k]) cnt[k] = 0;
        rst = 1'b1;
        drive(32'h0, 1'b0, 0, 1'b0);
        tick();
        tick();
        drive(32'h0, 1'b1, 3, 1'b1);
        chk("reset_ready", 32'(bus.ready_o), 32'd0);
        rst = 1'b0;
        sweep_wait();
        check_all_taken();
        for (int k = 0; k < 4; k++) begin
            drive(pc_for(5), 1'b1, 5, 1'b0);
            tick();
            drive(pc_for(5), 1'b0, 0, 1'b0);
            chk("sat_down", 32'(bus.predict_o), 32'(exp_down[k]));
        end
        for (int k = 0; k < 4; k++) begin
            drive(pc_for(5), 1'b1, 5, 1'b1);
            tick();
            drive(pc_for(5), 1'b0, 0, 1'b0);
            chk("sat_up", 32'(bus.predict_o), 32'(exp_up[k]));
        end
        drive(pc_for(5), 1'b1, 5, 1'b0);
        tick();
        drive(pc_for(5), 1'b1, 5, 1'b0);
        chk("hazard_same", 32'(bus.predict_o), 32'd1);
        tick();
        drive(pc_for(5), 1'b0, 0, 1'b0);
        chk("hazard_next", 32'(bus.predict_o), 32'd0);
        for (int k = 0; k < 400; k++) begin
            rand_drive();
            tick();
        end
        rst = 1'b1;
        drive(32'h0, 1'b0, 0, 1'b0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 7; k++) begin
            rand_drive();
            tick();
        end
        rst = 1'b1;
        drive(32'h0, 1'b0, 0, 1'b0);
        tick();
        rst = 1'b0;
        sweep_wait();
        chk("ghr_after_init", 32'(bus.ghr_o), 32'd0);
        check_all_taken();
`ifdef BRANCH_PREDICTOR_GSHARE_EN
        drive(32'h0, 1'b1, 2, 1'b1); tick();
        drive(32'h0, 1'b1, 2, 1'b0); tick();
        drive(32'h0, 1'b1, 2, 1'b1); tick();
        drive(32'h0, 1'b1, 2, 1'b1); tick();
        drive(32'h0, 1'b0, 0, 1'b0);
        chk("gshare_ghr", 32'(bus.ghr_o), 32'hB);
        chk("gshare_idx0", 32'(bus.lookup_idx_o), 32'hB);
        drive(32'h2C, 1'b0, 0, 1'b0);
        chk("gshare_idx2c", 32'(bus.lookup_idx_o), 32'h0);
`endif
        for (int k = 0; k < 200; k++) begin
            rand_drive();
            tick();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
